wb_regfile: RTL and testbench

Write-back stage and architectural register file for the 5-stage MIPS pipeline. Consumes the MEM/WB pipeline register outputs, selects the write-back value (memory load data or ALU result) and commits it into a 32-entry register file. Provides two combinational read ports to the decode stage and a write-back value/valid pair to the forwarding unit. Keeps a retired-write counter for performance monitoring.

---
 rtl/wb_regfile.sv | 134 +++++++++++++
 tb/tb_wb_regfile.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_regfile.sv
// ---------------------------------------------------------------------------
// wb_regfile -- write-back stage and architectural register file
//
// Purpose:
//   Selects the write-back value from the MEM/WB pipeline register (load data
//   or ALU result), commits it into a 2**ADDR_W entry register file and serves
//   two combinational read ports to decode. Register 0 always reads as zero.
//   A free-running retired-write counter supports performance monitoring.
//
// Build option:
//   WB_BYPASS_EN  when defined, a read port whose index matches the register
//                 being written this cycle returns wb_data before the commit
//                 edge (write-first). When undefined, read ports return the
//                 stored contents only.
//
// Ports:
//   clk            in   pipeline clock, rising edge
//   rst_n          in   asynchronous active-low reset
//   reg_write_in   in   write enable from MEM/WB
//   mem_to_reg_in  in   1 = write back read_data_in, 0 = alu_res_in
//   read_data_in   in   [DATA_W] load data from MEM/WB
//   alu_res_in     in   [DATA_W] ALU result from MEM/WB
//   write_reg_in   in   [ADDR_W] destination register index
//   rs_addr        in   [ADDR_W] read port A index
//   rt_addr        in   [ADDR_W] read port B index
//   rs_data        out  [DATA_W] read port A data (combinational)
//   rt_data        out  [DATA_W] read port B data (combinational)
//   wb_data        out  [DATA_W] selected write-back value (combinational)
//   wb_valid       out  write enable qualified by a non-zero destination
//   retire_count   out  [32] cycles with reg_write_in = 1 (registered)
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module wb_regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              reg_write_in,
  input  logic              mem_to_reg_in,
  input  logic [DATA_W-1:0] read_data_in,
  input  logic [DATA_W-1:0] alu_res_in,
  input  logic [ADDR_W-1:0] write_reg_in,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  output logic [DATA_W-1:0] wb_data,
  output logic              wb_valid,
  output logic [31:0]       retire_count
);

  localparam int NUM_REGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [31:0]       retire_q;
  logic [31:0]       retire_d;

  // -------------------------------------------------------------------------
  // Write-back select and commit qualifier
  // -------------------------------------------------------------------------
  always_comb begin
    wb_data  = mem_to_reg_in ? read_data_in : alu_res_in;
    // Writes to $0 are dropped here so entry 0 never leaves its reset value.
    wb_valid = reg_write_in && (write_reg_in != '0);
  end

  // -------------------------------------------------------------------------
  // Register array
  // -------------------------------------------------------------------------
  // NOTE: every entry is reset so architectural state is never X; this
  // deliberately maps the array onto flops rather than a RAM macro, which
  // could not be cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wb_valid) begin
      regs_q[write_reg_in] <= wb_data;
    end
  end

  // -------------------------------------------------------------------------
  // Read ports
  // -------------------------------------------------------------------------
  // Index 0 is forced to zero at the port as well, so a $0 read never depends
  // on the array contents or the bypass path.
  function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] addr);
    logic [DATA_W-1:0] val;
    val = regs_q[addr];
`ifdef WB_BYPASS_EN
    // wb_valid already excludes index 0, so the match never fires for $0.
    if (wb_valid && (addr == write_reg_in)) begin
      val = wb_data;
    end
`endif
    if (addr == '0) begin
      val = '0;
    end
    return val;
  endfunction

  // NOTE: each combinational output is assigned on every path through the
  // block, so no latch can be inferred.
  always_comb begin
    rs_data = read_port(rs_addr);
    rt_data = read_port(rt_addr);
  end

  // -------------------------------------------------------------------------
  // Retired-write counter; counts $0 writes too and wraps naturally.
  // -------------------------------------------------------------------------
  always_comb begin
    retire_d = retire_q;
    if (reg_write_in) begin
      retire_d = retire_q + 32'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retire_q <= '0;
    end else begin
      retire_q <= retire_d;
    end
  end

  assign retire_count = retire_q;

endmodule

// File: tb/tb_wb_regfile.sv
// ---------------------------------------------------------------------------
// tb_wb_regfile -- self-checking bench for wb_regfile
//
// A reference model (plain array + counter) tracks architectural state; a
// compare process checks every DUT output against it on each falling clock
// edge. Directed sequences add literal expectations for the key scenarios.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_wb_regfile;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk;
  logic          rst_n;
  logic          reg_write_in;
  logic          mem_to_reg_in;
  logic [DW-1:0] read_data_in;
  logic [DW-1:0] alu_res_in;
  logic [AW-1:0] write_reg_in;
  logic [AW-1:0] rs_addr;
  logic [AW-1:0] rt_addr;
  logic [DW-1:0] rs_data;
  logic [DW-1:0] rt_data;
  logic [DW-1:0] wb_data;
  logic          wb_valid;
  logic [31:0]   retire_count;

  wb_regfile #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .reg_write_in  (reg_write_in),
    .mem_to_reg_in (mem_to_reg_in),
    .read_data_in  (read_data_in),
    .alu_res_in    (alu_res_in),
    .write_reg_in  (write_reg_in),
    .rs_addr       (rs_addr),
    .rt_addr       (rt_addr),
    .rs_data       (rs_data),
    .rt_data       (rt_data),
    .wb_data       (wb_data),
    .wb_valid      (wb_valid),
    .retire_count  (retire_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  bit cmp_en  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // -------------------------------------------------------------------------
  // Reference model
  // -------------------------------------------------------------------------
  logic [DW-1:0] m_regs [32];
  logic [31:0]   m_count;

  initial begin
    foreach (m_regs[i]) m_regs[i] = '0;
    m_count = '0;
  end

  function automatic logic [DW-1:0] m_wb();
    return mem_to_reg_in ? read_data_in : alu_res_in;
  endfunction

  function automatic logic m_valid();
    return reg_write_in && (write_reg_in != 0);
  endfunction

  function automatic logic [DW-1:0] m_read(input logic [AW-1:0] a);
    if (a == 0) return '0;
`ifdef WB_BYPASS_EN
    if (m_valid() && a == write_reg_in) return m_wb();
`endif
    return m_regs[a];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      foreach (m_regs[i]) m_regs[i] = '0;
      m_count = '0;
    end else begin
      if (m_valid()) m_regs[write_reg_in] = m_wb();
      if (reg_write_in) m_count = m_count + 32'd1;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("cmp_rs_data",  rs_data,          m_read(rs_addr));
      check("cmp_rt_data",  rt_data,          m_read(rt_addr));
      check("cmp_wb_data",  wb_data,          m_wb());
      check("cmp_wb_valid", {31'd0, wb_valid}, {31'd0, m_valid()});
      check("cmp_retire",   retire_count,     m_count);
    end
  end

  // -------------------------------------------------------------------------
  // Stimulus helpers: inputs change 1ns after the rising edge.
  // -------------------------------------------------------------------------
  task automatic drive(input logic we, input logic m2r, input logic [DW-1:0] rd,
                       input logic [DW-1:0] alu, input logic [AW-1:0] wr,
                       input logic [AW-1:0] ra, input logic [AW-1:0] rb);
    reg_write_in  = we;
    mem_to_reg_in = m2r;
    read_data_in  = rd;
    alu_res_in    = alu;
    write_reg_in  = wr;
    rs_addr       = ra;
    rt_addr       = rb;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] cnt_before;
  logic [DW-1:0] back_vals [3];

  initial begin
    back_vals[0] = 32'd1;
    back_vals[1] = 32'd2;
    back_vals[2] = 32'd3;

    rst_n = 1'b1;
    drive(1'b0, 1'b0, '0, '0, '0, '0, '0);
    #1 rst_n = 1'b0;
    #1;
    check("reset_retire", retire_count, 32'd0);
    check("reset_rs", rs_data, 32'd0);
    tick();
    #2 rst_n = 1'b1;
    cmp_en = 1'b1;
    tick();

    // Random writes, then asynchronous reset mid-cycle clears everything.
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'($urandom), $urandom, $urandom, 5'($urandom_range(1, 31)),
            5'($urandom), 5'($urandom));
      tick();
    end
    reg_write_in = 1'b0;
    #2 rst_n = 1'b0;
    for (int i = 0; i < 32; i++) begin
      rs_addr = 5'(i);
      rt_addr = 5'(31 - i);
      #1;
      check("rst_all_rs", rs_data, 32'd0);
      check("rst_all_rt", rt_data, 32'd0);
    end
    check("rst_retire", retire_count, 32'd0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    tick();

    // Write-back select: load data, then ALU result.
    drive(1'b1, 1'b1, 32'hDEADBEEF, 32'h12345678, 5'd5, 5'd5, 5'd0);
    tick();
    check("sel_mem", rs_data, 32'hDEADBEEF);
    check("model_sel_mem", m_regs[5], 32'hDEADBEEF);
    drive(1'b1, 1'b0, 32'hDEADBEEF, 32'h12345678, 5'd5, 5'd5, 5'd5);
    tick();
    check("sel_alu", rs_data, 32'h12345678);
    check("sel_alu_rt", rt_data, 32'h12345678);

    // Zero register: write dropped, still counted.
    cnt_before = retire_count;
    drive(1'b1, 1'b0, 32'h0, 32'hFFFFFFFF, 5'd0, 5'd0, 5'd0);
    #1;
    check("zero_wb_valid", {31'd0, wb_valid}, 32'd0);
    check("zero_wb_data", wb_data, 32'hFFFFFFFF);
    tick();
    check("zero_rs", rs_data, 32'd0);
    check("zero_rt", rt_data, 32'd0);
    check("zero_counted", retire_count, cnt_before + 32'd1);

    // Bypass vs. stored-value read on the register being written.
    drive(1'b1, 1'b0, 32'h0, 32'h11111111, 5'd7, 5'd0, 5'd0);
    tick();
    drive(1'b1, 1'b0, 32'h0, 32'hA5A5A5A5, 5'd7, 5'd7, 5'd7);
    #1;
`ifdef WB_BYPASS_EN
    check("bypass_rs_pre", rs_data, 32'hA5A5A5A5);
    check("bypass_rt_pre", rt_data, 32'hA5A5A5A5);
`else
    check("nobypass_rs_pre", rs_data, 32'h11111111);
    check("nobypass_rt_pre", rt_data, 32'h11111111);
`endif
    tick();
    check("bypass_rs_post", rs_data, 32'hA5A5A5A5);
    check("bypass_rt_post", rt_data, 32'hA5A5A5A5);

    // Back-to-back writes to the same index.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, back_vals[i], 32'hBAD0BAD0, 5'd9, 5'd0, 5'd9);
      tick();
      check("b2b_rt", rt_data, back_vals[i]);
    end
    reg_write_in = 1'b0;
    tick();
    check("b2b_final", rt_data, 32'd3);

    // Reset asserted during a pending write: the write is lost.
    drive(1'b1, 1'b0, 32'h0, 32'h77777777, 5'd10, 5'd10, 5'd9);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 reg_write_in = 1'b0;
    #1;
    check("rst_write_lost", rs_data, 32'd0);
    check("rst_clears_9", rt_data, 32'd0);
    #1 rst_n = 1'b1;
    tick();

    // Counter wrap via backdoor preload.
    force dut.retire_q = 32'hFFFFFFFF;
    #1 release dut.retire_q;
    m_count = 32'hFFFFFFFF;
    #1;
    check("wrap_preload", retire_count, 32'hFFFFFFFF);
    drive(1'b1, 1'b0, 32'h0, 32'h00000042, 5'd3, 5'd3, 5'd3);
    tick();
    check("wrap_to_zero", retire_count, 32'd0);
    check("wrap_write", rs_data, 32'h00000042);
    reg_write_in = 1'b0;
    tick();
    check("idle_no_incr", retire_count, 32'd0);
    tick();

    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

endmodule
